core_d2e_operand_stage: RTL and testbench

- Decode-to-execute boundary stage that directly feeds core_alu.
- Buffers one decoded instruction, plus one skid entry, behind a valid/ready handshake.
- Keeps the held register operands fresh by snooping the execute and writeback result buses.
- Drives the ALU operands (op1, op2) and the ALU opcode for the instruction at its head.

---
 rtl/core_pkg.sv | 58 +++++
 rtl/core_operand_snoop.sv | 32 +++
 rtl/core_d2e_operand_stage.sv | 172 +++++++++++++++++
 tb/tb_core_d2e_operand_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared core datapath types.
//   word_t / reg_idx_t      : datapath word and register index
//   alu_op_t                : ALU opcode, shared with core_alu
//   op1_sel_t / op2_sel_t   : ALU operand source selects
//   d2e_state_t             : decode-to-execute buffer occupancy
//   d2e_entry_t             : one buffered decoded instruction
package core_pkg;

    localparam int CORE_XLEN      = 32;
    localparam int CORE_REG_IDX_W = 5;

    typedef logic [CORE_XLEN-1:0]      word_t;
    typedef logic [CORE_REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9
    } alu_op_t;

    typedef enum logic {
        OP1_RS1 = 1'b0,
        OP1_PC  = 1'b1
    } op1_sel_t;

    typedef enum logic {
        OP2_RS2 = 1'b0,
        OP2_IMM = 1'b1
    } op2_sel_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } d2e_state_t;

    typedef struct packed {
        reg_idx_t rs1_idx;
        reg_idx_t rs2_idx;
        word_t    rs1_val;
        word_t    rs2_val;
        word_t    pc;
        word_t    imm;
        op1_sel_t op1_sel;
        op2_sel_t op2_sel;
        alu_op_t  alu_op;
        reg_idx_t rd_idx;
        logic     rd_we;
    } d2e_entry_t;

endpackage

// File: rtl/core_operand_snoop.sv
// core_operand_snoop: refreshes one register operand from the result buses.
//   idx      : architectural source register of the operand
//   cur_val  : value currently held for that operand
//   fwd_e_*  : result leaving execute (youngest, wins on a double match)
//   fwd_w_*  : writeback result
//   next_val : cur_val, or the matching forwarded result
// x0 is never replaced, so a write to x0 on either bus cannot leak in.
module core_operand_snoop
    import core_pkg::*;
(
    input  reg_idx_t idx,
    input  word_t    cur_val,
    input  logic     fwd_e_valid,
    input  reg_idx_t fwd_e_rd_idx,
    input  word_t    fwd_e_value,
    input  logic     fwd_w_valid,
    input  reg_idx_t fwd_w_rd_idx,
    input  word_t    fwd_w_value,
    output word_t    next_val
);

    always_comb begin
        next_val = cur_val;
        if (idx != '0) begin
            if (fwd_e_valid && (fwd_e_rd_idx == idx))
                next_val = fwd_e_value;
            else if (fwd_w_valid && (fwd_w_rd_idx == idx))
                next_val = fwd_w_value;
        end
    end

endmodule

// File: rtl/core_d2e_operand_stage.sv
// core_d2e_operand_stage: decode-to-execute boundary in front of core_alu.
//   d_*       : decoded instruction in, valid/ready (d_ready registered)
//   fwd_e_*   : execute result bus, snooped into held operands
//   fwd_w_*   : writeback result bus, snooped into held operands
//   e_*       : head instruction out, valid/ready, ALU operands and opcode
//   flush     : drop every buffered entry (redirect)
// Two entries (main + skid) let d_ready be a flop while still sustaining
// one instruction per cycle. Every held rs value is refreshed each cycle
// so an instruction stalled here never executes with a stale operand.
module core_d2e_operand_stage
    import core_pkg::*;
#(
    parameter int XLEN      = CORE_XLEN,
    parameter int REG_IDX_W = CORE_REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 d_valid,
    output logic                 d_ready,
    input  logic [REG_IDX_W-1:0] d_rs1_idx,
    input  logic [REG_IDX_W-1:0] d_rs2_idx,
    input  logic [XLEN-1:0]      d_rs1_val,
    input  logic [XLEN-1:0]      d_rs2_val,
    input  logic [XLEN-1:0]      d_pc,
    input  logic [XLEN-1:0]      d_imm,
    input  logic                 d_op1_sel,
    input  logic                 d_op2_sel,
    input  logic [3:0]           d_alu_op,
    input  logic [REG_IDX_W-1:0] d_rd_idx,
    input  logic                 d_rd_we,
    input  logic                 fwd_e_valid,
    input  logic [REG_IDX_W-1:0] fwd_e_rd_idx,
    input  logic [XLEN-1:0]      fwd_e_value,
    input  logic                 fwd_w_valid,
    input  logic [REG_IDX_W-1:0] fwd_w_rd_idx,
    input  logic [XLEN-1:0]      fwd_w_value,
    output logic                 e_valid,
    input  logic                 e_ready,
    output logic [XLEN-1:0]      e_op1,
    output logic [XLEN-1:0]      e_op2,
    output logic [3:0]           e_alu_op,
    output logic [REG_IDX_W-1:0] e_rd_idx,
    output logic                 e_rd_we
);

    localparam int NUM_SRC  = 3;
    localparam int SRC_MAIN = 0;
    localparam int SRC_SKID = 1;
    localparam int SRC_IN   = 2;

    d2e_state_t state;
    d2e_entry_t main_q;
    d2e_entry_t skid_q;

    d2e_entry_t [NUM_SRC-1:0] src;
    d2e_entry_t [NUM_SRC-1:0] fresh;
    word_t      [NUM_SRC-1:0] rs1_nx;
    word_t      [NUM_SRC-1:0] rs2_nx;

    logic fire_in;
    logic fire_out;

    assign fire_in  = d_valid & d_ready;
    assign fire_out = e_valid & e_ready;

    // Snoop sources: both held entries plus the instruction being offered.
    always_comb begin
        src[SRC_MAIN]         = main_q;
        src[SRC_SKID]         = skid_q;
        src[SRC_IN].rs1_idx   = d_rs1_idx;
        src[SRC_IN].rs2_idx   = d_rs2_idx;
        src[SRC_IN].rs1_val   = d_rs1_val;
        src[SRC_IN].rs2_val   = d_rs2_val;
        src[SRC_IN].pc        = d_pc;
        src[SRC_IN].imm       = d_imm;
        src[SRC_IN].op1_sel   = op1_sel_t'(d_op1_sel);
        src[SRC_IN].op2_sel   = op2_sel_t'(d_op2_sel);
        src[SRC_IN].alu_op    = alu_op_t'(d_alu_op);
        src[SRC_IN].rd_idx    = d_rd_idx;
        src[SRC_IN].rd_we     = d_rd_we;
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_snoop
        core_operand_snoop u_rs1 (
            .idx          (src[g].rs1_idx),
            .cur_val      (src[g].rs1_val),
            .fwd_e_valid  (fwd_e_valid),
            .fwd_e_rd_idx (fwd_e_rd_idx),
            .fwd_e_value  (fwd_e_value),
            .fwd_w_valid  (fwd_w_valid),
            .fwd_w_rd_idx (fwd_w_rd_idx),
            .fwd_w_value  (fwd_w_value),
            .next_val     (rs1_nx[g])
        );
        core_operand_snoop u_rs2 (
            .idx          (src[g].rs2_idx),
            .cur_val      (src[g].rs2_val),
            .fwd_e_valid  (fwd_e_valid),
            .fwd_e_rd_idx (fwd_e_rd_idx),
            .fwd_e_value  (fwd_e_value),
            .fwd_w_valid  (fwd_w_valid),
            .fwd_w_rd_idx (fwd_w_rd_idx),
            .fwd_w_value  (fwd_w_value),
            .next_val     (rs2_nx[g])
        );

        always_comb begin
            fresh[g]         = src[g];
            fresh[g].rs1_val = rs1_nx[g];
            fresh[g].rs2_val = rs2_nx[g];
        end
    end

    // Occupancy FSM. Held entries take their snooped values every cycle;
    // the case arms below override main/skid where an entry moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            d_ready <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            main_q <= fresh[SRC_MAIN];
            skid_q <= fresh[SRC_SKID];
            if (flush) begin
                // A handoff in this cycle already happened; execute squashes it.
                state   <= ST_EMPTY;
                d_ready <= 1'b1;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        if (fire_in) begin
                            main_q <= fresh[SRC_IN];
                            state  <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (fire_in && !fire_out) begin
                            skid_q  <= fresh[SRC_IN];
                            state   <= ST_TWO;
                            d_ready <= 1'b0;
                        end else if (fire_in && fire_out) begin
                            main_q <= fresh[SRC_IN];
                        end else if (fire_out) begin
                            state <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (fire_out) begin
                            main_q  <= fresh[SRC_SKID];
                            state   <= ST_ONE;
                            d_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_EMPTY;
                        d_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign e_valid  = (state != ST_EMPTY);
    assign e_op1    = (main_q.op1_sel == OP1_PC)  ? main_q.pc  : main_q.rs1_val;
    assign e_op2    = (main_q.op2_sel == OP2_IMM) ? main_q.imm : main_q.rs2_val;
    assign e_alu_op = main_q.alu_op;
    assign e_rd_idx = main_q.rd_idx;
    assign e_rd_we  = main_q.rd_we;

endmodule

// File: tb/tb_core_d2e_operand_stage.sv
// Directed bench for core_d2e_operand_stage with a handoff scoreboard.
module tb_core_d2e_operand_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, d_valid, d_ready;
    logic [4:0]  d_rs1_idx, d_rs2_idx, d_rd_idx;
    logic [31:0] d_rs1_val, d_rs2_val, d_pc, d_imm;
    logic        d_op1_sel, d_op2_sel, d_rd_we;
    logic [3:0]  d_alu_op;
    logic        fwd_e_valid, fwd_w_valid;
    logic [4:0]  fwd_e_rd_idx, fwd_w_rd_idx;
    logic [31:0] fwd_e_value, fwd_w_value;
    logic        e_valid, e_ready, e_rd_we;
    logic [31:0] e_op1, e_op2;
    logic [3:0]  e_alu_op;
    logic [4:0]  e_rd_idx;

    always #5 clk = ~clk;

    core_d2e_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_rs1_idx(d_rs1_idx), .d_rs2_idx(d_rs2_idx),
        .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val),
        .d_pc(d_pc), .d_imm(d_imm),
        .d_op1_sel(d_op1_sel), .d_op2_sel(d_op2_sel),
        .d_alu_op(d_alu_op), .d_rd_idx(d_rd_idx), .d_rd_we(d_rd_we),
        .fwd_e_valid(fwd_e_valid), .fwd_e_rd_idx(fwd_e_rd_idx), .fwd_e_value(fwd_e_value),
        .fwd_w_valid(fwd_w_valid), .fwd_w_rd_idx(fwd_w_rd_idx), .fwd_w_value(fwd_w_value),
        .e_valid(e_valid), .e_ready(e_ready),
        .e_op1(e_op1), .e_op2(e_op2), .e_alu_op(e_alu_op),
        .e_rd_idx(e_rd_idx), .e_rd_we(e_rd_we)
    );

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sbq[$];
    exp_t mx;
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic expect_out(input logic [31:0] op1, input logic [31:0] op2,
                              input logic [3:0] alu, input logic [4:0] rd, input logic we);
        exp_t x;
        x.op1 = op1; x.op2 = op2; x.alu = alu; x.rd = rd; x.we = we;
        sbq.push_back(x);
    endtask

    // Monitor: every handoff must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && e_valid && e_ready) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_out: got op1=%h op2=%h expected no handoff at %0t",
                         e_op1, e_op2, $time);
            end else begin
                mx = sbq.pop_front();
                chk("out_op1", e_op1, mx.op1);
                chk("out_op2", e_op2, mx.op2);
                chk("out_alu", 32'(e_alu_op), 32'(mx.alu));
                chk("out_rd",  32'({e_rd_we, e_rd_idx}), 32'({mx.we, mx.rd}));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs1i, input logic [31:0] rs1v,
                         input logic [4:0] rs2i, input logic [31:0] rs2v,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic s1, input logic s2, input logic [3:0] op,
                         input logic [4:0] rd, input logic we);
        d_rs1_idx = rs1i; d_rs1_val = rs1v; d_rs2_idx = rs2i; d_rs2_val = rs2v;
        d_pc = pc; d_imm = imm; d_op1_sel = s1; d_op2_sel = s2;
        d_alu_op = op; d_rd_idx = rd; d_rd_we = we;
    endtask

    // Offer the driven instruction until accepted; returns #1 after the accepting edge.
    task automatic push();
        logic acc;
        d_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            acc = d_ready;
            cyc();
            if (acc) begin
                d_valid = 1'b0;
                return;
            end
        end
        d_valid = 1'b0;
        nvec++;
        nerr++;
        $display("FAIL push_timeout: got d_ready=0 for 20 cycles expected acceptance");
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; e_ready = 1'b1;
        fwd_e_valid = 1'b0; fwd_e_rd_idx = '0; fwd_e_value = '0;
        fwd_w_valid = 1'b0; fwd_w_rd_idx = '0; fwd_w_value = '0;
        set_d(5'd1, 32'h1111, 5'd2, 32'h2222, 32'h40, 32'h4, 1'b0, 1'b0, ALU_ADD, 5'd1, 1'b1);
        d_valid = 1'b1;

        // Reset with d_valid held high: nothing is captured.
        repeat (2) begin
            @(negedge clk);
            chk("rst_e_valid", 32'(e_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        d_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_d_ready", 32'(d_ready), 32'd1);
        chk("post_rst_e_valid", 32'(e_valid), 32'd0);
        cyc();

        // Basic rs1 + imm, one-cycle latency.
        set_d(5'd1, 32'd5, 5'd2, 32'd9, 32'h80, 32'd7, 1'b0, 1'b1, ALU_ADD, 5'd1, 1'b1);
        expect_out(32'd5, 32'd7, ALU_ADD, 5'd1, 1'b1);
        push();
        chk("lat_e_valid", 32'(e_valid), 32'd1);
        chk("lat_e_op1", e_op1, 32'd5);
        chk("lat_e_op2", e_op2, 32'd7);
        chk("lat_e_alu", 32'(e_alu_op), 32'(ALU_ADD));
        cyc();

        // Fill main + skid while stalled, then drain in order.
        e_ready = 1'b0;
        set_d(5'd1, 32'h11, 5'd2, 32'h22, 32'h100, 32'h0, 1'b0, 1'b0, ALU_OR, 5'd7, 1'b1);
        expect_out(32'h11, 32'h22, ALU_OR, 5'd7, 1'b1);
        push();
        set_d(5'd1, 32'h33, 5'd2, 32'h44, 32'h200, 32'hFFFF_FFF0, 1'b1, 1'b1, ALU_AND, 5'd8, 1'b0);
        expect_out(32'h200, 32'hFFFF_FFF0, ALU_AND, 5'd8, 1'b0);
        push();
        chk("full_d_ready", 32'(d_ready), 32'd0);
        e_ready = 1'b1;
        cyc();
        chk("drain_d_ready", 32'(d_ready), 32'd1);
        cyc();
        chk("drain_e_valid", 32'(e_valid), 32'd0);
        e_ready = 1'b0;

        // Stalled head picks up W, then E over W.
        set_d(5'd3, 32'h0, 5'd4, 32'h22, 32'h300, 32'd5, 1'b0, 1'b0, ALU_SUB, 5'd9, 1'b1);
        push();
        fwd_w_valid = 1'b1; fwd_w_rd_idx = 5'd3; fwd_w_value = 32'h1234;
        cyc();
        fwd_w_valid = 1'b0;
        chk("snoop_w_op1", e_op1, 32'h1234);
        fwd_e_valid = 1'b1; fwd_e_rd_idx = 5'd3; fwd_e_value = 32'hAAAA;
        fwd_w_valid = 1'b1; fwd_w_rd_idx = 5'd3; fwd_w_value = 32'hBBBB;
        cyc();
        fwd_e_valid = 1'b0; fwd_w_valid = 1'b0;
        chk("snoop_e_prio_op1", e_op1, 32'hAAAA);
        chk("snoop_e_prio_op2", e_op2, 32'h22);
        expect_out(32'hAAAA, 32'h22, ALU_SUB, 5'd9, 1'b1);
        e_ready = 1'b1;
        cyc();
        e_ready = 1'b0;

        // Capture and forward in the same cycle, then snoop main and skid.
        set_d(5'd5, 32'h55, 5'd6, 32'h1, 32'h400, 32'd0, 1'b0, 1'b0, ALU_XOR, 5'd10, 1'b1);
        fwd_e_valid = 1'b1; fwd_e_rd_idx = 5'd6; fwd_e_value = 32'h6666;
        push();
        fwd_e_valid = 1'b0;
        chk("capture_snoop_op2", e_op2, 32'h6666);
        set_d(5'd12, 32'h0, 5'd13, 32'h13, 32'h404, 32'd0, 1'b0, 1'b0, ALU_SLT, 5'd11, 1'b1);
        push();
        fwd_e_valid = 1'b1; fwd_e_rd_idx = 5'd6;  fwd_e_value = 32'h7777;
        fwd_w_valid = 1'b1; fwd_w_rd_idx = 5'd12; fwd_w_value = 32'hC0C0;
        cyc();
        fwd_e_valid = 1'b0; fwd_w_valid = 1'b0;
        expect_out(32'h55, 32'h7777, ALU_XOR, 5'd10, 1'b1);
        expect_out(32'hC0C0, 32'h13, ALU_SLT, 5'd11, 1'b1);
        e_ready = 1'b1;
        repeat (2) cyc();
        e_ready = 1'b0;

        // x0 is never forwarded.
        set_d(5'd0, 32'h0, 5'd0, 32'h0, 32'h500, 32'd0, 1'b0, 1'b0, ALU_ADD, 5'd0, 1'b0);
        push();
        fwd_e_valid = 1'b1; fwd_e_rd_idx = 5'd0; fwd_e_value = 32'hFFFF_FFFF;
        fwd_w_valid = 1'b1; fwd_w_rd_idx = 5'd0; fwd_w_value = 32'hFFFF_FFFF;
        cyc();
        fwd_e_valid = 1'b0; fwd_w_valid = 1'b0;
        chk("x0_op1", e_op1, 32'h0);
        chk("x0_op2", e_op2, 32'h0);
        expect_out(32'h0, 32'h0, ALU_ADD, 5'd0, 1'b0);
        e_ready = 1'b1;
        cyc();
        e_ready = 1'b0;

        // Flush in TWO with a new input offered: everything disappears.
        set_d(5'd1, 32'hE1, 5'd2, 32'hE1, 32'h600, 32'd0, 1'b0, 1'b0, ALU_SRL, 5'd14, 1'b1);
        push();
        set_d(5'd1, 32'hE2, 5'd2, 32'hE2, 32'h604, 32'd0, 1'b0, 1'b0, ALU_SRA, 5'd15, 1'b1);
        push();
        set_d(5'd1, 32'hF0F0, 5'd2, 32'hF0F0, 32'h608, 32'd0, 1'b0, 1'b0, ALU_SLL, 5'd16, 1'b1);
        d_valid = 1'b1; flush = 1'b1;
        cyc();
        d_valid = 1'b0; flush = 1'b0;
        chk("flush_e_valid", 32'(e_valid), 32'd0);
        chk("flush_d_ready", 32'(d_ready), 32'd1);
        e_ready = 1'b1;
        repeat (3) cyc();

        // Stage is usable after flush; op1 from PC.
        set_d(5'd2, 32'h1, 5'd2, 32'h99, 32'hDEAD_0000, 32'd3, 1'b1, 1'b0, ALU_SLTU, 5'd17, 1'b1);
        expect_out(32'hDEAD_0000, 32'h99, ALU_SLTU, 5'd17, 1'b1);
        push();
        cyc();
        e_ready = 1'b0;

        // Handoff in the flush cycle still counts.
        set_d(5'd1, 32'h77, 5'd2, 32'h88, 32'h700, 32'd0, 1'b0, 1'b0, ALU_AND, 5'd18, 1'b1);
        expect_out(32'h77, 32'h88, ALU_AND, 5'd18, 1'b1);
        push();
        e_ready = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0; e_ready = 1'b0;
        chk("flush_out_e_valid", 32'(e_valid), 32'd0);

        // Reset mid-operation discards both entries.
        set_d(5'd1, 32'hA1, 5'd2, 32'hA2, 32'h800, 32'd0, 1'b0, 1'b0, ALU_OR, 5'd19, 1'b1);
        push();
        push();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_e_valid", 32'(e_valid), 32'd0);
        chk("mid_rst_d_ready", 32'(d_ready), 32'd1);
        e_ready = 1'b1;
        repeat (3) cyc();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
